// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit holding the MIPS HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, with sign fix-up at the end.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [1:0]         op_q;      // bit0: unsigned, bit1: divide
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   ma, mb;
  logic               neg_q, neg_r;
  logic [2*WIDTH-1:0] prod;      // product, or quotient in the low half while dividing
  logic [WIDTH-1:0]   rem;

  logic               is_signed;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;
  logic               ge;
  logic [WIDTH:0]     rem_next;
  logic [2*WIDTH-1:0] prod_fix;

  always_comb begin
    is_signed = ~op_q[0];
    mag_a     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    mag_b     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
    sum       = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, ma} : '0);
    shifted   = {rem, prod[WIDTH-1]};
    ge        = (shifted >= {1'b0, mb});
    rem_next  = ge ? (shifted - {1'b0, mb}) : shifted;
    prod_fix  = neg_q ? -prod : prod;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      ma    <= '0;
      mb    <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      prod  <= '0;
      rem   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                a_q   <= a;
                b_q   <= b;
                op_q  <= op[1:0];
                busy  <= 1'b1;
                state <= PREP;
              end
              3'b100: begin
                hi   <= a;
                done <= 1'b1;
              end
              3'b101: begin
                lo   <= a;
                done <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        PREP: begin
          ma    <= mag_a;
          mb    <= op_q[1] ? mag_b : mag_b;
          neg_q <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_r <= is_signed & a_q[WIDTH-1];
          prod  <= {{WIDTH{1'b0}}, (op_q[1] ? mag_a : mag_b)};
          rem   <= '0;
          cnt   <= CW'(WIDTH - 1);
          state <= ITER;
        end
        ITER: begin
          if (op_q[1]) begin
            rem               <= rem_next[WIDTH-1:0];
            prod[WIDTH-1:0]   <= {prod[WIDTH-2:0], ge};
          end else begin
            prod <= {sum, prod[WIDTH-1:1]};
          end
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: begin
          if (op_q[1]) begin
            if (b_q == '0) begin
              // Divide by zero: quotient saturates, remainder is the dividend.
              lo <= '1;
              hi <= a_q;
            end else begin
              lo <= neg_q ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
              hi <= neg_r ? -rem : rem;
            end
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
